// File: rtl/dec.sv
// Decode stage for an RV32I pipeline.
//
// Splits a raw instruction word into a decoded operation plus three packed
// operands. A 32-bit scoreboard of pending destination registers stalls
// instructions whose sources are still being produced.
//
// Handshake semantics (both sides): a transfer happens on a rising clk_i edge
// when valid and ready are both high. Once valid is raised, the offered data
// stays stable until the transfer. Ready may depend combinationally on the
// other side's valid/ready.
//
// Build option: define ECAP5_DPROC_ILLEGAL_INSTR_EN to consume unknown
// encodings and pulse illegal_o instead of forwarding them as a NOP.

package ecap5_dproc_pkg;

  typedef enum logic [5:0] {
    INSTR_NONE,
    INSTR_LUI,   INSTR_AUIPC, INSTR_JAL,   INSTR_JALR,
    INSTR_BEQ,   INSTR_BNE,   INSTR_BLT,   INSTR_BGE,   INSTR_BLTU,  INSTR_BGEU,
    INSTR_LB,    INSTR_LH,    INSTR_LW,    INSTR_LBU,   INSTR_LHU,
    INSTR_SB,    INSTR_SH,    INSTR_SW,
    INSTR_ADDI,  INSTR_SLTI,  INSTR_SLTIU, INSTR_XORI,  INSTR_ORI,   INSTR_ANDI,
    INSTR_SLLI,  INSTR_SRLI,  INSTR_SRAI,
    INSTR_ADD,   INSTR_SUB,   INSTR_SLL,   INSTR_SLT,   INSTR_SLTU,  INSTR_XOR,
    INSTR_SRL,   INSTR_SRA,   INSTR_OR,    INSTR_AND,
    INSTR_FENCE, INSTR_ECALL, INSTR_EBREAK
  } instr_t;

endpackage

module dec (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    input_valid_i,
  output logic                    input_ready_o,
  input  logic [31:0]             pc_i,
  input  logic [31:0]             instr_i,

  output logic [4:0]              rs1_addr_o,
  output logic [4:0]              rs2_addr_o,
  input  logic [31:0]             rs1_data_i,
  input  logic [31:0]             rs2_data_i,

  output logic                    output_valid_o,
  input  logic                    output_ready_i,
  output logic [31:0]             pc_o,
  output ecap5_dproc_pkg::instr_t instr_o,
  output logic [31:0]             param1_o,
  output logic [31:0]             param2_o,
  output logic [31:0]             param3_o,

  input  logic                    wb_write_i,
  input  logic [4:0]              wb_addr_i,

  input  logic                    flush_i,
  output logic                    illegal_o
);

  import ecap5_dproc_pkg::*;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  // Sign-extended immediates
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic [31:0] u_imm;
  logic [31:0] j_imm;

  assign i_imm = {{20{instr_i[31]}}, instr_i[31:20]};
  assign s_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign b_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign u_imm = {instr_i[31:12], 12'b0};
  assign j_imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  // Decoder results
  logic        d_known;
  instr_t      d_instr;
  logic [31:0] d_p1;
  logic [31:0] d_p2;
  logic [31:0] d_p3;
  logic        d_writes;
  logic        d_use_rs1;
  logic        d_use_rs2;
  logic        dec_legal;

  // Output register and scoreboard state
  logic        valid_q;
  logic [31:0] pc_q;
  instr_t      instr_q;
  logic [31:0] p1_q;
  logic [31:0] p2_q;
  logic [31:0] p3_q;
  logic        writes_q;
  logic [4:0]  rd_q;
  logic [31:0] sb_q;

  logic        hazard;
  logic        accept;
  logic        out_fire;

  // Decode the current instruction word into operation and packed operands
  always_comb begin
    d_known   = 1'b0;
    d_instr   = INSTR_NONE;
    d_p1      = 32'h0;
    d_p2      = 32'h0;
    d_p3      = 32'h0;
    d_writes  = 1'b0;
    d_use_rs1 = 1'b0;
    d_use_rs2 = 1'b0;
    case (opcode)
      OP_LUI: begin
        d_known  = 1'b1;
        d_instr  = INSTR_LUI;
        d_p2     = u_imm;
        d_p3     = {27'b0, rd};
        d_writes = 1'b1;
      end
      OP_AUIPC: begin
        d_known  = 1'b1;
        d_instr  = INSTR_AUIPC;
        d_p1     = pc_i;
        d_p2     = u_imm;
        d_p3     = {27'b0, rd};
        d_writes = 1'b1;
      end
      OP_JAL: begin
        d_known  = 1'b1;
        d_instr  = INSTR_JAL;
        d_p1     = pc_i;
        d_p2     = j_imm;
        d_p3     = {27'b0, rd};
        d_writes = 1'b1;
      end
      OP_JALR: begin
        d_known   = (funct3 == 3'b000);
        d_instr   = INSTR_JALR;
        d_p1      = rs1_data_i;
        d_p2      = i_imm;
        d_p3      = {27'b0, rd};
        d_writes  = 1'b1;
        d_use_rs1 = 1'b1;
      end
      OP_BRANCH: begin
        d_known   = 1'b1;
        d_p1      = rs1_data_i;
        d_p2      = rs2_data_i;
        d_p3      = b_imm;
        d_use_rs1 = 1'b1;
        d_use_rs2 = 1'b1;
        case (funct3)
          3'b000:  d_instr = INSTR_BEQ;
          3'b001:  d_instr = INSTR_BNE;
          3'b100:  d_instr = INSTR_BLT;
          3'b101:  d_instr = INSTR_BGE;
          3'b110:  d_instr = INSTR_BLTU;
          3'b111:  d_instr = INSTR_BGEU;
          default: d_known = 1'b0;
        endcase
      end
      OP_LOAD: begin
        d_known   = 1'b1;
        d_p1      = rs1_data_i;
        d_p2      = i_imm;
        d_p3      = {27'b0, rd};
        d_writes  = 1'b1;
        d_use_rs1 = 1'b1;
        case (funct3)
          3'b000:  d_instr = INSTR_LB;
          3'b001:  d_instr = INSTR_LH;
          3'b010:  d_instr = INSTR_LW;
          3'b100:  d_instr = INSTR_LBU;
          3'b101:  d_instr = INSTR_LHU;
          default: d_known = 1'b0;
        endcase
      end
      OP_STORE: begin
        d_known   = 1'b1;
        d_p1      = rs1_data_i;
        d_p2      = s_imm;
        d_p3      = rs2_data_i;
        d_use_rs1 = 1'b1;
        d_use_rs2 = 1'b1;
        case (funct3)
          3'b000:  d_instr = INSTR_SB;
          3'b001:  d_instr = INSTR_SH;
          3'b010:  d_instr = INSTR_SW;
          default: d_known = 1'b0;
        endcase
      end
      OP_IMM: begin
        d_known   = 1'b1;
        d_p1      = rs1_data_i;
        d_p2      = i_imm;
        d_p3      = {27'b0, rd};
        d_writes  = 1'b1;
        d_use_rs1 = 1'b1;
        case (funct3)
          3'b000: d_instr = INSTR_ADDI;
          3'b010: d_instr = INSTR_SLTI;
          3'b011: d_instr = INSTR_SLTIU;
          3'b100: d_instr = INSTR_XORI;
          3'b110: d_instr = INSTR_ORI;
          3'b111: d_instr = INSTR_ANDI;
          3'b001: begin
            d_instr = INSTR_SLLI;
            d_known = (funct7 == 7'b0000000);
          end
          default: begin
            if (funct7 == 7'b0100000) begin
              d_instr = INSTR_SRAI;
            end else begin
              d_instr = INSTR_SRLI;
              d_known = (funct7 == 7'b0000000);
            end
          end
        endcase
      end
      OP_REG: begin
        d_known   = 1'b1;
        d_p1      = rs1_data_i;
        d_p2      = rs2_data_i;
        d_p3      = {27'b0, rd};
        d_writes  = 1'b1;
        d_use_rs1 = 1'b1;
        d_use_rs2 = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: d_instr = INSTR_ADD;
          10'b0100000_000: d_instr = INSTR_SUB;
          10'b0000000_001: d_instr = INSTR_SLL;
          10'b0000000_010: d_instr = INSTR_SLT;
          10'b0000000_011: d_instr = INSTR_SLTU;
          10'b0000000_100: d_instr = INSTR_XOR;
          10'b0000000_101: d_instr = INSTR_SRL;
          10'b0100000_101: d_instr = INSTR_SRA;
          10'b0000000_110: d_instr = INSTR_OR;
          10'b0000000_111: d_instr = INSTR_AND;
          default:         d_known = 1'b0;
        endcase
      end
      OP_FENCE: begin
        d_known = (funct3 == 3'b000);
        d_instr = INSTR_FENCE;
      end
      OP_SYSTEM: begin
        if (instr_i[31:7] == 25'h0) begin
          d_known = 1'b1;
          d_instr = INSTR_ECALL;
        end else if (instr_i[31:7] == 25'h0002000) begin
          d_known = 1'b1;
          d_instr = INSTR_EBREAK;
        end
      end
      default: d_known = 1'b0;
    endcase
`ifndef ECAP5_DPROC_ILLEGAL_INSTR_EN
    // Unknown encodings become ADDI x0,x0,0: no sources, no destination
    if (!d_known) begin
      d_instr   = INSTR_ADDI;
      d_p1      = 32'h0;
      d_p2      = 32'h0;
      d_p3      = 32'h0;
      d_writes  = 1'b0;
      d_use_rs1 = 1'b0;
      d_use_rs2 = 1'b0;
    end
`endif
  end

`ifdef ECAP5_DPROC_ILLEGAL_INSTR_EN
  assign dec_legal = d_known;
`else
  assign dec_legal = 1'b1;
`endif

  // Source is blocked while pending in the scoreboard or held in the output register
  always_comb begin
    hazard = 1'b0;
    if (d_use_rs1 && rs1_addr_o != 5'd0) begin
      if (sb_q[rs1_addr_o] || (valid_q && writes_q && rd_q == rs1_addr_o)) begin
        hazard = 1'b1;
      end
    end
    if (d_use_rs2 && rs2_addr_o != 5'd0) begin
      if (sb_q[rs2_addr_o] || (valid_q && writes_q && rd_q == rs2_addr_o)) begin
        hazard = 1'b1;
      end
    end
  end

  assign input_ready_o = !hazard && !flush_i && (!valid_q || output_ready_i);
  assign accept        = input_valid_i && input_ready_o;
  assign out_fire      = valid_q && output_ready_i;

  // Output register: load on accept, drain on transfer, drop on flush or reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      pc_q     <= 32'h0;
      instr_q  <= INSTR_NONE;
      p1_q     <= 32'h0;
      p2_q     <= 32'h0;
      p3_q     <= 32'h0;
      writes_q <= 1'b0;
      rd_q     <= 5'd0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= dec_legal;
      if (dec_legal) begin
        pc_q     <= pc_i;
        instr_q  <= d_instr;
        p1_q     <= d_p1;
        p2_q     <= d_p2;
        p3_q     <= d_p3;
        writes_q <= d_writes && (rd != 5'd0);
        rd_q     <= rd;
      end
    end else if (output_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // Scoreboard: set on a writing instruction leaving, clear on writeback; set wins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_q <= 32'h0;
    end else begin
      logic [31:0] sb_next;
      sb_next = sb_q;
      if (wb_write_i) begin
        sb_next[wb_addr_i] = 1'b0;
      end
      if (out_fire && writes_q) begin
        sb_next[rd_q] = 1'b1;
      end
      sb_next[0] = 1'b0;
      sb_q <= sb_next;
    end
  end

`ifdef ECAP5_DPROC_ILLEGAL_INSTR_EN
  logic illegal_q;

  // One-cycle pulse when an unknown encoding is consumed
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && !d_known;
    end
  end

  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

  assign output_valid_o = valid_q;
  assign pc_o           = pc_q;
  assign instr_o        = instr_q;
  assign param1_o       = p1_q;
  assign param2_o       = p2_q;
  assign param3_o       = p3_q;

endmodule

// File: tb/tb_dec.sv
// Directed testbench for the decode stage.
import ecap5_dproc_pkg::*;

module tb_dec;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        input_valid_i;
  logic        input_ready_o;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        output_valid_o;
  logic        output_ready_i;
  logic [31:0] pc_o;
  instr_t      instr_o;
  logic [31:0] param1_o;
  logic [31:0] param2_o;
  logic [31:0] param3_o;
  logic        wb_write_i;
  logic [4:0]  wb_addr_i;
  logic        flush_i;
  logic        illegal_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_sb;
  logic [31:0] held_p1;

  localparam logic [31:0] I_ADDI_X5  = 32'hFFF08293; // addi x5,x1,-1
  localparam logic [31:0] I_ADD_X3   = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_SUB_X4   = 32'h40318233; // sub  x4,x3,x3
  localparam logic [31:0] I_SW       = 32'h0020A423; // sw   x2,8(x1)
  localparam logic [31:0] I_BEQ      = 32'hFE208EE3; // beq  x1,x2,-4
  localparam logic [31:0] I_LUI_X7   = 32'h123453B7; // lui  x7,0x12345
  localparam logic [31:0] I_AUIPC_X6 = 32'hFFFFF317; // auipc x6,0xfffff
  localparam logic [31:0] I_JAL_X1   = 32'h008000EF; // jal  x1,+8
  localparam logic [31:0] I_ADDI_X9  = 32'h00100493; // addi x9,x0,1
  localparam logic [31:0] I_ADDI_X10 = 32'h00200513; // addi x10,x0,2
  localparam logic [31:0] I_ADDI_X11 = 32'h00300593; // addi x11,x0,3

  dec dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .input_valid_i  (input_valid_i),
    .input_ready_o  (input_ready_o),
    .pc_i           (pc_i),
    .instr_i        (instr_i),
    .rs1_addr_o     (rs1_addr_o),
    .rs2_addr_o     (rs2_addr_o),
    .rs1_data_i     (rs1_data_i),
    .rs2_data_i     (rs2_data_i),
    .output_valid_o (output_valid_o),
    .output_ready_i (output_ready_i),
    .pc_o           (pc_o),
    .instr_o        (instr_o),
    .param1_o       (param1_o),
    .param2_o       (param2_o),
    .param3_o       (param3_o),
    .wb_write_i     (wb_write_i),
    .wb_addr_i      (wb_addr_i),
    .flush_i        (flush_i),
    .illegal_o      (illegal_o)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction and wait (bounded) for it to be accepted
  task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2);
    instr_i       = ins;
    pc_i          = pc;
    rs1_data_i    = r1;
    rs2_data_i    = r2;
    input_valid_i = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (input_ready_o) break;
    end
    check("send_ready", 32'(input_ready_o), 32'd1);
    @(posedge clk);
    #1;
    input_valid_i = 1'b0;
  endtask

  task automatic check_sb(input string tag);
    check(tag, dut.sb_q, exp_sb);
  endtask

  initial begin
    rst_i          = 1'b1;
    input_valid_i  = 1'b0;
    pc_i           = 32'h0;
    instr_i        = 32'h0;
    rs1_data_i     = 32'h0;
    rs2_data_i     = 32'h0;
    output_ready_i = 1'b1;
    wb_write_i     = 1'b0;
    wb_addr_i      = 5'd0;
    flush_i        = 1'b0;
    exp_sb         = 32'h0;

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(output_valid_o), 32'd0);
    check("rst_p1", param1_o, 32'h0);
    check("rst_p2", param2_o, 32'h0);
    check("rst_p3", param3_o, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_illegal", 32'(illegal_o), 32'd0);
    check_sb("rst_sb");
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(input_ready_o), 32'd1);
    tick();

    // ADDI x5,x1,-1
    send(I_ADDI_X5, 32'h100, 32'h10, 32'h0);
    check("addi_valid", 32'(output_valid_o), 32'd1);
    check("addi_instr", 32'(instr_o), 32'(INSTR_ADDI));
    check("addi_pc", pc_o, 32'h100);
    check("addi_p1", param1_o, 32'h10);
    check("addi_p2", param2_o, 32'hFFFFFFFF);
    check("addi_p3", param3_o, 32'd5);
    tick();
    exp_sb[5] = 1'b1;
    check("addi_drain", 32'(output_valid_o), 32'd0);
    check_sb("addi_sb");

    // LUI / AUIPC
    send(I_LUI_X7, 32'h104, 32'hDEAD, 32'hBEEF);
    check("lui_p1", param1_o, 32'h0);
    check("lui_p2", param2_o, 32'h12345000);
    check("lui_p3", param3_o, 32'd7);
    tick();
    exp_sb[7] = 1'b1;
    send(I_AUIPC_X6, 32'h108, 32'h0, 32'h0);
    check("auipc_p1", param1_o, 32'h108);
    check("auipc_p2", param2_o, 32'hFFFFF000);
    check("auipc_p3", param3_o, 32'd6);
    tick();
    exp_sb[6] = 1'b1;

    // Store and branch do not write a register
    send(I_SW, 32'h10C, 32'h1000, 32'hCAFE);
    check("sw_instr", 32'(instr_o), 32'(INSTR_SW));
    check("sw_p1", param1_o, 32'h1000);
    check("sw_p2", param2_o, 32'd8);
    check("sw_p3", param3_o, 32'hCAFE);
    tick();
    send(I_BEQ, 32'h110, 32'h11, 32'h22);
    check("beq_p1", param1_o, 32'h11);
    check("beq_p2", param2_o, 32'h22);
    check("beq_p3", param3_o, 32'hFFFFFFFC);
    tick();
    check_sb("sw_beq_sb");

    // Stall with output register full
    output_ready_i = 1'b0;
    instr_i = I_ADD_X3;
    #1;
    check("rs1_addr", 32'(rs1_addr_o), 32'd1);
    check("rs2_addr", 32'(rs2_addr_o), 32'd2);
    send(I_ADD_X3, 32'h114, 32'd5, 32'd7);
    check("add_p3", param3_o, 32'd3);
    held_p1 = param1_o;
    check("add_p1", held_p1, 32'd5);
    instr_i       = I_SW;
    rs1_data_i    = 32'h99;
    input_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_ready", 32'(input_ready_o), 32'd0);
      check("stall_valid", 32'(output_valid_o), 32'd1);
      check("stall_p1", param1_o, 32'd5);
      check("stall_instr", 32'(instr_o), 32'(INSTR_ADD));
      tick();
    end

    // RAW hazard on x3 until writeback
    instr_i        = I_SUB_X4;
    rs1_data_i     = 32'd40;
    rs2_data_i     = 32'd40;
    output_ready_i = 1'b1;
    @(negedge clk);
    check("haz_outreg", 32'(input_ready_o), 32'd0);
    tick();
    exp_sb[3] = 1'b1;
    check_sb("haz_sb_set");
    @(negedge clk);
    check("haz_sb_ready", 32'(input_ready_o), 32'd0);
    tick();
    wb_write_i = 1'b1;
    wb_addr_i  = 5'd3;
    @(negedge clk);
    check("haz_wb_cycle", 32'(input_ready_o), 32'd0);
    tick();
    exp_sb[3] = 1'b0;
    wb_write_i = 1'b0;
    check_sb("haz_sb_clr");
    @(negedge clk);
    check("haz_released", 32'(input_ready_o), 32'd1);
    tick();
    input_valid_i = 1'b0;
    check("sub_valid", 32'(output_valid_o), 32'd1);
    check("sub_instr", 32'(instr_o), 32'(INSTR_SUB));
    check("sub_p3", param3_o, 32'd4);
    tick();
    exp_sb[4] = 1'b1;
    check_sb("sub_sb");

    // Flush while stalled drops the instruction without a scoreboard set
    output_ready_i = 1'b0;
    send(I_ADDI_X9, 32'h120, 32'h0, 32'h0);
    flush_i       = 1'b1;
    instr_i       = I_ADDI_X10;
    input_valid_i = 1'b1;
    @(negedge clk);
    check("flush_ready", 32'(input_ready_o), 32'd0);
    tick();
    flush_i       = 1'b0;
    input_valid_i = 1'b0;
    check("flush_valid", 32'(output_valid_o), 32'd0);
    check_sb("flush_sb");
    output_ready_i = 1'b1;
    tick();
    check_sb("flush_sb_after");

    // Flush coinciding with an output transfer still sets the scoreboard
    send(I_ADDI_X10, 32'h124, 32'h0, 32'h0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    exp_sb[10] = 1'b1;
    check("flushx_valid", 32'(output_valid_o), 32'd0);
    check_sb("flushx_sb");

    // Simultaneous set and clear of the same bit leaves it set
    send(I_ADDI_X11, 32'h128, 32'h0, 32'h0);
    wb_write_i = 1'b1;
    wb_addr_i  = 5'd11;
    tick();
    wb_write_i = 1'b0;
    exp_sb[11] = 1'b1;
    check_sb("setclr_sb");

    // JAL
    send(I_JAL_X1, 32'h200, 32'h0, 32'h0);
    check("jal_p1", param1_o, 32'h200);
    check("jal_p2", param2_o, 32'd8);
    check("jal_p3", param3_o, 32'd1);
    tick();
    exp_sb[1] = 1'b1;
    check_sb("jal_sb");

    // Reset mid-stall
    wb_write_i = 1'b1;
    wb_addr_i  = 5'd1;
    tick();
    wb_write_i = 1'b0;
    exp_sb[1] = 1'b0;
    send(I_ADD_X3, 32'h300, 32'd1, 32'd2);
    tick();
    exp_sb[3] = 1'b1;
    check_sb("pre_rst_sb");
    output_ready_i = 1'b0;
    send(I_ADDI_X9, 32'h304, 32'h0, 32'h0);
    tick();
    rst_i = 1'b1;
    tick();
    exp_sb = 32'h0;
    check_sb("midrst_sb");
    check("midrst_valid", 32'(output_valid_o), 32'd0);
    check("midrst_p2", param2_o, 32'h0);
    rst_i          = 1'b0;
    output_ready_i = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(input_ready_o), 32'd1);
    tick();

    // All-ones word is not a valid encoding
    send(32'hFFFFFFFF, 32'h400, 32'h55, 32'h66);
`ifdef ECAP5_DPROC_ILLEGAL_INSTR_EN
    check("ill_pulse", 32'(illegal_o), 32'd1);
    check("ill_valid", 32'(output_valid_o), 32'd0);
    tick();
    check("ill_pulse_end", 32'(illegal_o), 32'd0);
    check("ill_valid_after", 32'(output_valid_o), 32'd0);
`else
    check("nop_valid", 32'(output_valid_o), 32'd1);
    check("nop_instr", 32'(instr_o), 32'(INSTR_ADDI));
    check("nop_p1", param1_o, 32'h0);
    check("nop_p2", param2_o, 32'h0);
    check("nop_p3", param3_o, 32'h0);
    check("nop_illegal", 32'(illegal_o), 32'd0);
    tick();
`endif
    check_sb("final_sb");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
